// File: rtl/conv_flatten_pkg.sv
// rtl/conv_flatten_pkg.sv - shared widths, csel codes and flatten FSM states
package conv_flatten_pkg;

  localparam int CONV_AW   = 12;
  localparam int CONV_DW   = 20;
  localparam int CONV_N_IN = 1024;

  // Memory select codes shared with the conv engine and the top-level bus mux
  localparam logic [2:0] CSEL_NONE  = 3'b000;
  localparam logic [2:0] CSEL_L0    = 3'b001;
  localparam logic [2:0] CSEL_L1_K0 = 3'b011;
  localparam logic [2:0] CSEL_L1_K1 = 3'b100;
  localparam logic [2:0] CSEL_L2    = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4,
    FIN  = 3'd5
  } flat_state_t;

endpackage

// File: rtl/conv_flatten.sv
// rtl/conv_flatten.sv - interleaves the two max-pool memories into the layer-2 memory
module conv_flatten
  import conv_flatten_pkg::*;
#(
  parameter int         N_IN      = CONV_N_IN,
  parameter int         AW        = CONV_AW,
  parameter int         DW        = CONV_DW,
  parameter logic [2:0] CSEL_SRC0 = CSEL_L1_K0,
  parameter logic [2:0] CSEL_SRC1 = CSEL_L1_K1,
  parameter logic [2:0] CSEL_DST  = CSEL_L2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  flat_state_t   state, state_n;
  logic [AW-1:0] k, k_n;
  logic [DW-1:0] d0, d0_n, d1, d1_n;
  logic          busy_n, done_n, crd_n, cwr_n;
  logic [AW-1:0] caddr_rd_n, caddr_wr_n;
  logic [DW-1:0] cdata_wr_n;
  logic [2:0]    csel_n;
  logic          k_last;

  assign k_last = (k == AW'(N_IN - 1));

  // Bus outputs are computed from the next state so they are registered
  // and already valid during the cycle the FSM sits in that state.
  always_comb begin
    state_n    = state;
    k_n        = k;
    d0_n       = d0;
    d1_n       = d1;
    busy_n     = busy;
    done_n     = 1'b0;
    crd_n      = 1'b0;
    cwr_n      = 1'b0;
    caddr_rd_n = caddr_rd;
    caddr_wr_n = caddr_wr;
    cdata_wr_n = cdata_wr;
    csel_n     = csel;
    case (state)
      IDLE: begin
        csel_n = CSEL_NONE;
        if (start) begin
          state_n    = RD0;
          busy_n     = 1'b1;
          k_n        = '0;
          crd_n      = 1'b1;
          csel_n     = CSEL_SRC0;
          caddr_rd_n = '0;
        end
      end
      RD0: begin
        d0_n       = cdata_rd;
        state_n    = RD1;
        crd_n      = 1'b1;
        csel_n     = CSEL_SRC1;
        caddr_rd_n = k;
      end
      RD1: begin
        d1_n       = cdata_rd;
        state_n    = WR0;
        cwr_n      = 1'b1;
        csel_n     = CSEL_DST;
        caddr_wr_n = {k[AW-2:0], 1'b0};
        cdata_wr_n = d0;
      end
      WR0: begin
        state_n    = WR1;
        cwr_n      = 1'b1;
        csel_n     = CSEL_DST;
        caddr_wr_n = {k[AW-2:0], 1'b1};
        cdata_wr_n = d1;
      end
      WR1: begin
        if (k_last) begin
          state_n = FIN;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          csel_n  = CSEL_NONE;
        end else begin
          k_n        = k + AW'(1);
          state_n    = RD0;
          crd_n      = 1'b1;
          csel_n     = CSEL_SRC0;
          caddr_rd_n = k + AW'(1);
        end
      end
      FIN: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        csel_n  = CSEL_NONE;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        csel_n  = CSEL_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      d0       <= '0;
      d1       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      csel     <= CSEL_NONE;
    end else begin
      state    <= state_n;
      k        <= k_n;
      d0       <= d0_n;
      d1       <= d1_n;
      busy     <= busy_n;
      done     <= done_n;
      crd      <= crd_n;
      cwr      <= cwr_n;
      caddr_rd <= caddr_rd_n;
      caddr_wr <= caddr_wr_n;
      cdata_wr <= cdata_wr_n;
      csel     <= csel_n;
    end
  end

endmodule

// File: tb/tb_conv_flatten.sv
// tb/tb_conv_flatten.sv - randomized self-checking bench for conv_flatten
module tb_conv_flatten;

  localparam int N = 1024;
  localparam logic [19:0] POISON = 20'h5A5A5;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, crd, cwr;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_rd, cdata_wr;
  logic [2:0]  csel;

  logic [19:0] src0 [N];
  logic [19:0] src1 [N];
  logic [19:0] l2   [2*N];
  logic [19:0] expv [2*N];

  int pass_cnt = 0;
  int total_cnt = 0;

  int   n_rd, n_wr, n_overlap, n_badsel, n_order, n_done, done_cycle, last_wr_cycle;
  logic busy_at_done, busy_pre;

  always #5 clk = ~clk;

  conv_flatten dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  assign cdata_rd = !crd ? 20'h0 :
                    (csel == 3'b011) ? src0[caddr_rd[9:0]] :
                    (csel == 3'b100) ? src1[caddr_rd[9:0]] : 20'h0;

  always @(posedge clk) begin
    if (cwr && csel == 3'b101) l2[caddr_wr[10:0]] = cdata_wr;
  end

  // Reference: layer-2 entry 2i holds kernel 0 element i, entry 2i+1 kernel 1 element i
  task automatic build_expected();
    for (int i = 0; i < 2*N; i++) expv[i] = (i % 2 == 0) ? src0[i/2] : src1[i/2];
  endtask

  function automatic int l2_errors();
    int e = 0;
    for (int i = 0; i < 2*N; i++) if (l2[i] !== expv[i]) e++;
    return e;
  endfunction

  task automatic clear_l2();
    for (int i = 0; i < 2*N; i++) l2[i] = POISON;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      src0[i] = 20'($urandom);
      src1[i] = 20'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Pulses start, then observes the bus each cycle and gathers statistics only
  task automatic run(input int extra_start_at, input int stop_at);
    int next_wr;
    n_rd = 0; n_wr = 0; n_overlap = 0; n_badsel = 0; n_order = 0; n_done = 0;
    done_cycle = -1; last_wr_cycle = -1; next_wr = 0;
    busy_at_done = 1'bx; busy_pre = 1'bx;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 5000; cyc++) begin
      if (crd) begin
        n_rd++;
        if (csel != 3'b011 && csel != 3'b100) n_badsel++;
      end
      if (cwr) begin
        n_wr++;
        if (csel != 3'b101) n_badsel++;
        if (int'(caddr_wr) != next_wr) n_order++;
        next_wr++;
        if (caddr_wr == 12'd2047) last_wr_cycle = cyc;
      end
      if (crd && cwr) n_overlap++;
      if (cyc == 4096) busy_pre = busy;
      if (done) begin
        n_done++;
        if (done_cycle < 0) begin
          done_cycle = cyc;
          busy_at_done = busy;
        end
      end
      if (cyc == stop_at) return;
      if (done_cycle > 0 && cyc >= done_cycle + 3) return;
      start = (cyc == extra_start_at);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0h expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %0h expected 0", done); else pass_cnt++;
    total_cnt++; if (crd !== 1'b0) $display("FAIL reset_crd: got %0h expected 0", crd); else pass_cnt++;
    total_cnt++; if (cwr !== 1'b0) $display("FAIL reset_cwr: got %0h expected 0", cwr); else pass_cnt++;
    total_cnt++; if (caddr_rd !== 12'h0) $display("FAIL reset_caddr_rd: got %0h expected 0", caddr_rd); else pass_cnt++;
    total_cnt++; if (caddr_wr !== 12'h0) $display("FAIL reset_caddr_wr: got %0h expected 0", caddr_wr); else pass_cnt++;
    total_cnt++; if (cdata_wr !== 20'h0) $display("FAIL reset_cdata_wr: got %0h expected 0", cdata_wr); else pass_cnt++;
    total_cnt++; if (csel !== 3'b000) $display("FAIL reset_csel: got %0h expected 0", csel); else pass_cnt++;
  endtask

  task automatic test_counting_pattern();
    for (int i = 0; i < N; i++) begin
      src0[i] = 20'(i);
      src1[i] = 20'h80000 | 20'(i);
    end
    build_expected();
    clear_l2();
    run(-1, -1);
    total_cnt++; if (l2_errors() != 0) $display("FAIL count_l2: got %0d bad entries expected 0", l2_errors()); else pass_cnt++;
    total_cnt++; if (done_cycle != 4097) $display("FAIL count_done_cycle: got %0d expected 4097", done_cycle); else pass_cnt++;
    total_cnt++; if (n_done != 1) $display("FAIL count_done_pulses: got %0d expected 1", n_done); else pass_cnt++;
    total_cnt++; if (busy_at_done !== 1'b0) $display("FAIL count_busy_at_done: got %0h expected 0", busy_at_done); else pass_cnt++;
    total_cnt++; if (busy_pre !== 1'b1) $display("FAIL count_busy_before_done: got %0h expected 1", busy_pre); else pass_cnt++;
    total_cnt++; if (n_rd != 2048) $display("FAIL count_reads: got %0d expected 2048", n_rd); else pass_cnt++;
    total_cnt++; if (n_wr != 2048) $display("FAIL count_writes: got %0d expected 2048", n_wr); else pass_cnt++;
    total_cnt++; if (n_overlap != 0) $display("FAIL count_rd_wr_overlap: got %0d expected 0", n_overlap); else pass_cnt++;
    total_cnt++; if (n_badsel != 0) $display("FAIL count_csel: got %0d bad cycles expected 0", n_badsel); else pass_cnt++;
    total_cnt++; if (n_order != 0) $display("FAIL count_wr_order: got %0d out-of-order expected 0", n_order); else pass_cnt++;
  endtask

  task automatic test_extremes();
    fill_random();
    src0[1023] = 20'hFFFFF;
    src1[1023] = 20'h00001;
    src0[0]    = 20'h7FFFF;
    build_expected();
    clear_l2();
    run(-1, -1);
    total_cnt++; if (l2_errors() != 0) $display("FAIL ext_l2: got %0d bad entries expected 0", l2_errors()); else pass_cnt++;
    total_cnt++; if (l2[2046] !== 20'hFFFFF) $display("FAIL ext_l2_2046: got %0h expected fffff", l2[2046]); else pass_cnt++;
    total_cnt++; if (l2[2047] !== 20'h00001) $display("FAIL ext_l2_2047: got %0h expected 1", l2[2047]); else pass_cnt++;
    total_cnt++; if (l2[0] !== 20'h7FFFF) $display("FAIL ext_l2_0: got %0h expected 7ffff", l2[0]); else pass_cnt++;
    total_cnt++; if (!(last_wr_cycle > 0 && last_wr_cycle < done_cycle))
      $display("FAIL ext_last_write_before_done: got write %0d done %0d expected write earlier", last_wr_cycle, done_cycle);
    else pass_cnt++;
  endtask

  task automatic test_double_start();
    fill_random();
    build_expected();
    clear_l2();
    run(100, -1);
    total_cnt++; if (done_cycle != 4097) $display("FAIL dbl_done_cycle: got %0d expected 4097", done_cycle); else pass_cnt++;
    total_cnt++; if (n_done != 1) $display("FAIL dbl_done_pulses: got %0d expected 1", n_done); else pass_cnt++;
    total_cnt++; if (n_wr != 2048) $display("FAIL dbl_writes: got %0d expected 2048", n_wr); else pass_cnt++;
    total_cnt++; if (l2_errors() != 0) $display("FAIL dbl_l2: got %0d bad entries expected 0", l2_errors()); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int strobes;
    fill_random();
    build_expected();
    clear_l2();
    run(-1, 2000);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    total_cnt++; if ({busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel} !== 51'h0)
      $display("FAIL mrst_outputs: got %0h expected 0", {busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel});
    else pass_cnt++;
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      if (crd || cwr || busy) strobes++;
      @(posedge clk);
      #1;
    end
    total_cnt++; if (strobes != 0) $display("FAIL mrst_quiet: got %0d active cycles expected 0", strobes); else pass_cnt++;
    total_cnt++; if (l2[999] !== expv[999]) $display("FAIL mrst_partial_last: got %0h expected %0h", l2[999], expv[999]); else pass_cnt++;
    total_cnt++; if (l2[1000] !== POISON) $display("FAIL mrst_untouched: got %0h expected %0h", l2[1000], POISON); else pass_cnt++;
    fill_random();
    build_expected();
    run(-1, -1);
    total_cnt++; if (l2_errors() != 0) $display("FAIL mrst_rerun_l2: got %0d bad entries expected 0", l2_errors()); else pass_cnt++;
    total_cnt++; if (done_cycle != 4097) $display("FAIL mrst_rerun_done: got %0d expected 4097", done_cycle); else pass_cnt++;
    total_cnt++; if (n_order != 0) $display("FAIL mrst_rerun_order: got %0d out-of-order expected 0", n_order); else pass_cnt++;
  endtask

  task automatic test_reset_with_start();
    int active;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    active = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy || crd || cwr) active++;
      @(posedge clk);
      #1;
    end
    total_cnt++; if (active != 0) $display("FAIL rst_start_idle: got %0d active cycles expected 0", active); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_counting_pattern();
    test_extremes();
    test_double_start();
    test_mid_reset();
    test_reset_with_start();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
